// File: rtl/serialin_if.sv
// Signal bundle between the input scanner, its external 74HC165 chain and the host.
// slave is the scanner side; master is the board/host side.
interface serialin_if #(
    parameter int unsigned WIDTH = 8
);
    logic             en;
    logic             sdata;
    logic             sclk;
    logic             load_n;
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             changed;
    logic             busy;

    modport slave (
        input  en,
        input  sdata,
        output sclk,
        output load_n,
        output data,
        output valid,
        output changed,
        output busy
    );

    modport master (
        output en,
        output sdata,
        input  sclk,
        input  load_n,
        input  data,
        input  valid,
        input  changed,
        input  busy
    );
endinterface

// File: rtl/serialin.sv
// Scanner for an external parallel-in/serial-out register chain: load, shift WIDTH bits in,
// then publish the whole word with a one-cycle valid (and changed) pulse.
module serialin #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 4
) (
    input logic       clk,
    input logic       rst_n,
    serialin_if.slave bus
);
    localparam int unsigned CntW = $clog2(DIV);
    localparam int unsigned BitW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] DivMax = CntW'(DIV - 1);
    localparam logic [BitW-1:0] BitMax = BitW'(WIDTH - 1);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StLoad = 3'd1;
    localparam logic [2:0] StShLo = 3'd2;
    localparam logic [2:0] StShHi = 3'd3;
    localparam logic [2:0] StDone = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CntW-1:0]  div_cnt_q, div_cnt_d;
    logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             changed_q, changed_d;
    logic [1:0]       sync_q, sync_d;
    logic             sclk_q, sclk_d;
    logic             load_n_q, load_n_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] sr_shift;
    logic             phase_end;

    assign phase_end = (div_cnt_q == '0);

    if (WIDTH == 1) begin : g_sr_single
        assign sr_shift = sync_q[1];
    end else begin : g_sr_multi
        assign sr_shift = {sr_q[WIDTH-2:0], sync_q[1]};
    end

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        changed_d = 1'b0;
        sync_d    = {sync_q[0], bus.sdata};

        unique case (state_q)
            StIdle: begin
                if (bus.en) begin
                    state_d   = StLoad;
                    div_cnt_d = DivMax;
                end
            end
            StLoad: begin
                bit_cnt_d = '0;
                if (phase_end) begin
                    state_d   = StShLo;
                    div_cnt_d = DivMax;
                end else begin
                    div_cnt_d = div_cnt_q - 1'b1;
                end
            end
            StShLo: begin
                if (phase_end) begin
                    sr_d      = sr_shift;
                    state_d   = StShHi;
                    div_cnt_d = DivMax;
                end else begin
                    div_cnt_d = div_cnt_q - 1'b1;
                end
            end
            StShHi: begin
                if (phase_end) begin
                    div_cnt_d = DivMax;
                    if (bit_cnt_q == BitMax) begin
                        // Publish on entry to DONE so data and valid change on the same edge.
                        state_d   = StDone;
                        data_d    = sr_q;
                        valid_d   = 1'b1;
                        changed_d = (sr_q != data_q);
                    end else begin
                        state_d   = StShLo;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q - 1'b1;
                end
            end
            StDone: begin
                div_cnt_d = DivMax;
                state_d   = bus.en ? StLoad : StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Strobes registered from next state to keep the off-board lines glitch-free.
        sclk_d   = (state_d == StShHi);
        load_n_d = (state_d != StLoad);
        busy_d   = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            sr_q      <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            sync_q    <= '0;
            sclk_q    <= 1'b0;
            load_n_q  <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            sr_q      <= sr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
            sync_q    <= sync_d;
            sclk_q    <= sclk_d;
            load_n_q  <= load_n_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.sclk    = sclk_q;
    assign bus.load_n  = load_n_q;
    assign bus.data    = data_q;
    assign bus.valid   = valid_q;
    assign bus.changed = changed_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_serialin.sv
// Bench for serialin: 74HC165 models on two instances (8/4 and 1/3), scoreboard of
// expected {changed, data} words checked on each valid pulse.
module tb_serialin;
    localparam int FRAME  = 4 * (1 + 2 * 8) + 1;  // 69
    localparam int FRAME1 = 3 * (1 + 2 * 1) + 1;  // 10

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [8:0] exp_q[$];
    logic [1:0] exp1_q[$];

    serialin_if #(.WIDTH(8)) bus ();
    serialin_if #(.WIDTH(1)) bus1 ();

    serialin #(.WIDTH(8), .DIV(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    serialin #(.WIDTH(1), .DIV(3)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    // External shift register models: parallel load while load_n low, shift on sclk rise.
    logic [7:0] pins = 8'h00;
    logic [7:0] shreg = 8'h00;
    logic       sclk_prev = 1'b0;
    always @(posedge clk) begin
        sclk_prev <= bus.sclk;
        if (bus.load_n == 1'b0) shreg <= pins;
        else if (bus.sclk == 1'b1 && sclk_prev == 1'b0) shreg <= {shreg[6:0], 1'b0};
    end
    assign bus.sdata = shreg[7];

    logic pins1 = 1'b0;
    logic shreg1 = 1'b0;
    logic sclk1_prev = 1'b0;
    always @(posedge clk) begin
        sclk1_prev <= bus1.sclk;
        if (bus1.load_n == 1'b0) shreg1 <= pins1;
        else if (bus1.sclk == 1'b1 && sclk1_prev == 1'b0) shreg1 <= 1'b0;
    end
    assign bus1.sdata = shreg1;

    task automatic wait_valid(input int limit, output int cyc);
        cyc = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (bus.valid === 1'b1) begin
                cyc = i;
                return;
            end
        end
    endtask

    task automatic wait_valid1(input int limit, output int cyc);
        cyc = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (bus1.valid === 1'b1) begin
                cyc = i;
                return;
            end
        end
    endtask

    task automatic test_reset;
        int cyc;
        logic [8:0] exp;
        rst_n = 1'b0;
        bus.en = 1'b1;
        bus1.en = 1'b0;
        pins = 8'h5A;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.sclk, bus.load_n, bus.valid, bus.changed, bus.busy} !== 5'b01000) begin
            errors++;
            $display("FAIL reset_ctrl: sclk,load_n,valid,changed,busy=%b expected 01000",
                     {bus.sclk, bus.load_n, bus.valid, bus.changed, bus.busy});
        end
        checks++;
        if (bus.data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got %h expected 00", bus.data);
        end
        exp_q.push_back({1'b1, 8'h5A});
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.load_n !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: load_n=%b busy=%b expected 0 1", bus.load_n, bus.busy);
        end
        bus.en = 1'b0;
        wait_valid(FRAME + 5, cyc);
        checks++;
        if (cyc != FRAME - 1) begin
            errors++;
            $display("FAIL reset_frame_len: valid at %0d expected %0d", cyc, FRAME - 1);
        end
        if (cyc != 0) begin
            exp = exp_q.pop_front();
            checks++;
            if ({bus.changed, bus.data} !== exp) begin
                errors++;
                $display("FAIL reset_word: got changed=%b data=%h expected changed=%b data=%h",
                         bus.changed, bus.data, exp[8], exp[7:0]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_single;
        int lo_cnt = 0, hi_cnt = 0, rise_cnt = 0, vcnt = 0, vcyc = 0;
        logic prev_sclk = 1'b0;
        logic busy_at_v = 1'b0, busy_after = 1'b1;
        logic [8:0] exp;
        pins = 8'hA5;
        exp_q.push_back({1'b1, 8'hA5});
        bus.en = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        for (int i = 1; i <= FRAME + 1; i++) begin
            if (bus.load_n === 1'b0) lo_cnt++;
            if (bus.sclk === 1'b1) hi_cnt++;
            if (bus.sclk === 1'b1 && prev_sclk === 1'b0) rise_cnt++;
            prev_sclk = bus.sclk;
            if (i == FRAME) busy_at_v = bus.busy;
            if (i == FRAME + 1) busy_after = bus.busy;
            if (bus.valid === 1'b1) begin
                vcnt++;
                vcyc = i;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL single_sb: valid at %0d with no expected word", i);
                end else begin
                    exp = exp_q.pop_front();
                    checks++;
                    if ({bus.changed, bus.data} !== exp) begin
                        errors++;
                        $display("FAIL single_word: got changed=%b data=%h expected changed=%b data=%h",
                                 bus.changed, bus.data, exp[8], exp[7:0]);
                    end
                end
            end
            @(negedge clk);
        end
        checks++;
        if (lo_cnt != 4) begin
            errors++;
            $display("FAIL single_load_len: load_n low %0d cycles expected 4", lo_cnt);
        end
        checks++;
        if (rise_cnt != 8 || hi_cnt != 32) begin
            errors++;
            $display("FAIL single_sclk: rises=%0d high=%0d expected 8 32", rise_cnt, hi_cnt);
        end
        checks++;
        if (vcnt != 1 || vcyc != FRAME) begin
            errors++;
            $display("FAIL single_valid: count=%0d at %0d expected 1 at %0d", vcnt, vcyc, FRAME);
        end
        checks++;
        if (busy_at_v !== 1'b1 || busy_after !== 1'b0) begin
            errors++;
            $display("FAIL single_busy: at valid=%b after=%b expected 1 0", busy_at_v, busy_after);
        end
    endtask

    task automatic test_continuous;
        int c = 0, nv = 0;
        int vt[3] = '{0, 0, 0};
        logic [8:0] exp;
        pins = 8'h3C;
        exp_q.push_back({1'b1, 8'h3C});
        exp_q.push_back({1'b0, 8'h3C});
        bus.en = 1'b1;
        while (nv < 3 && c < 4 * FRAME) begin
            @(negedge clk);
            c++;
            if (bus.valid === 1'b1) begin
                vt[nv] = c;
                nv++;
                exp = exp_q.pop_front();
                checks++;
                if ({bus.changed, bus.data} !== exp) begin
                    errors++;
                    $display("FAIL cont_word%0d: got changed=%b data=%h expected changed=%b data=%h",
                             nv, bus.changed, bus.data, exp[8], exp[7:0]);
                end
                if (nv == 2) begin
                    pins = 8'hC3;
                    exp_q.push_back({1'b1, 8'hC3});
                end
                if (nv == 3) bus.en = 1'b0;
            end
        end
        bus.en = 1'b0;
        checks++;
        if (nv != 3) begin
            errors++;
            $display("FAIL cont_timeout: saw %0d valid pulses expected 3", nv);
        end
        checks++;
        if (vt[0] != FRAME || vt[1] - vt[0] != FRAME || vt[2] - vt[1] != FRAME) begin
            errors++;
            $display("FAIL cont_spacing: valid at %0d %0d %0d expected %0d %0d %0d",
                     vt[0], vt[1], vt[2], FRAME, 2 * FRAME, 3 * FRAME);
        end
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_en_drop;
        int vcyc = 0, lo_cnt = 0, hi_cnt = 0, busy_cnt = 0;
        logic [8:0] exp;
        pins = 8'h96;
        exp_q.push_back({1'b1, 8'h96});
        bus.en = 1'b1;
        for (int i = 1; i <= FRAME + 4; i++) begin
            @(negedge clk);
            if (i == 30) bus.en = 1'b0;
            if (bus.valid === 1'b1) begin
                vcyc = i;
                exp = exp_q.pop_front();
                checks++;
                if ({bus.changed, bus.data} !== exp) begin
                    errors++;
                    $display("FAIL endrop_word: got changed=%b data=%h expected changed=%b data=%h",
                             bus.changed, bus.data, exp[8], exp[7:0]);
                end
            end
        end
        checks++;
        if (vcyc != FRAME) begin
            errors++;
            $display("FAIL endrop_valid: valid at %0d expected %0d", vcyc, FRAME);
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (bus.load_n !== 1'b1) lo_cnt++;
            if (bus.sclk !== 1'b0) hi_cnt++;
            if (bus.busy !== 1'b0) busy_cnt++;
        end
        checks++;
        if (lo_cnt != 0 || hi_cnt != 0 || busy_cnt != 0) begin
            errors++;
            $display("FAIL endrop_idle: load_n low=%0d sclk high=%0d busy=%0d expected 0 0 0",
                     lo_cnt, hi_cnt, busy_cnt);
        end
    endtask

    task automatic test_reset_mid;
        int cyc, vcnt = 0;
        logic [8:0] exp;
        pins = 8'hFF;
        exp_q.push_back({1'b1, 8'hFF});
        bus.en = 1'b1;
        wait_valid(FRAME + 5, cyc);
        bus.en = 1'b0;
        checks++;
        if (cyc != FRAME) begin
            errors++;
            $display("FAIL rstmid_pre_valid: valid at %0d expected %0d", cyc, FRAME);
        end
        if (cyc != 0) begin
            exp = exp_q.pop_front();
            checks++;
            if ({bus.changed, bus.data} !== exp) begin
                errors++;
                $display("FAIL rstmid_pre_word: got changed=%b data=%h expected changed=%b data=%h",
                         bus.changed, bus.data, exp[8], exp[7:0]);
            end
        end
        @(negedge clk);
        pins = 8'h81;
        bus.en = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (i == 1) bus.en = 1'b0;
            if (bus.valid === 1'b1) vcnt++;
        end
        checks++;
        if (bus.sclk !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_in_shhi: sclk=%b expected 1 at bit 5 high phase", bus.sclk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({bus.sclk, bus.load_n, bus.valid, bus.busy, bus.data} !== {4'b0100, 8'h00}) begin
            errors++;
            $display("FAIL rstmid_state: sclk=%b load_n=%b valid=%b busy=%b data=%h expected 0 1 0 0 00",
                     bus.sclk, bus.load_n, bus.valid, bus.busy, bus.data);
        end
        for (int i = 0; i < FRAME + 10; i++) begin
            @(negedge clk);
            if (bus.valid === 1'b1) vcnt++;
        end
        checks++;
        if (vcnt != 0) begin
            errors++;
            $display("FAIL rstmid_no_valid: saw %0d valid pulses expected 0", vcnt);
        end
        exp_q.push_back({1'b1, 8'h81});
        bus.en = 1'b1;
        wait_valid(FRAME + 5, cyc);
        bus.en = 1'b0;
        checks++;
        if (cyc != FRAME) begin
            errors++;
            $display("FAIL rstmid_post_valid: valid at %0d expected %0d", cyc, FRAME);
        end
        if (cyc != 0) begin
            exp = exp_q.pop_front();
            checks++;
            if ({bus.changed, bus.data} !== exp) begin
                errors++;
                $display("FAIL rstmid_post_word: got changed=%b data=%h expected changed=%b data=%h",
                         bus.changed, bus.data, exp[8], exp[7:0]);
            end
        end
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_width1;
        int cyc, nv = 0;
        int vt[2] = '{0, 0};
        logic [1:0] exp;
        pins1 = 1'b1;
        exp1_q.push_back(2'b11);
        bus1.en = 1'b1;
        wait_valid1(FRAME1 + 5, cyc);
        bus1.en = 1'b0;
        checks++;
        if (cyc != FRAME1) begin
            errors++;
            $display("FAIL w1_valid: valid at %0d expected %0d", cyc, FRAME1);
        end
        if (cyc != 0) begin
            exp = exp1_q.pop_front();
            checks++;
            if ({bus1.changed, bus1.data} !== exp) begin
                errors++;
                $display("FAIL w1_word: got changed=%b data=%b expected changed=%b data=%b",
                         bus1.changed, bus1.data, exp[1], exp[0]);
            end
        end
        exp1_q.delete();
        repeat (3) @(negedge clk);
        exp1_q.push_back(2'b01);
        bus1.en = 1'b1;
        for (int i = 1; i <= 4 * FRAME1 && nv < 2; i++) begin
            @(negedge clk);
            if (i == 8) begin
                checks++;
                if (bus1.sclk !== 1'b1) begin
                    errors++;
                    $display("FAIL w1_in_shhi: sclk=%b expected 1 at cycle 8", bus1.sclk);
                end
                pins1 = 1'b0;
                exp1_q.push_back(2'b10);
            end
            if (bus1.valid === 1'b1) begin
                vt[nv] = i;
                nv++;
                if (nv == 2) bus1.en = 1'b0;
                exp = exp1_q.pop_front();
                checks++;
                if ({bus1.changed, bus1.data} !== exp) begin
                    errors++;
                    $display("FAIL w1_repeat_word%0d: got changed=%b data=%b expected changed=%b data=%b",
                             nv, bus1.changed, bus1.data, exp[1], exp[0]);
                end
            end
        end
        bus1.en = 1'b0;
        checks++;
        if (nv != 2 || vt[0] != FRAME1 || vt[1] != 2 * FRAME1) begin
            errors++;
            $display("FAIL w1_repeat_timing: %0d pulses at %0d %0d expected 2 at %0d %0d",
                     nv, vt[0], vt[1], FRAME1, 2 * FRAME1);
        end
        exp1_q.delete();
    endtask

    initial begin
        bus.en = 1'b0;
        bus1.en = 1'b0;
        test_reset();
        test_single();
        test_continuous();
        test_en_drop();
        test_reset_mid();
        test_width1();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
